// File: rtl/sample_frame_collector.sv
// sample_frame_collector
// Packs DEPTH serial WIDTH-bit samples into one parallel frame for the
// downstream frame FIFO. A fill buffer and an output register form a
// double buffer, so a finished frame can wait for the consumer while the
// next frame is being collected. up_last closes a short frame early, and
// the unused upper slots of that frame are zero-padded.
module sample_frame_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic                             up_valid,
  output logic                             up_ready,
  input  logic [WIDTH-1:0]                 up_data,
  input  logic                             up_last,
  output logic                             down_valid,
  input  logic                             down_ready,
  output logic [DEPTH-1:0][WIDTH-1:0]      down_data,
  output logic [$clog2(DEPTH+1)-1:0]       down_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]            fill_idx;
  logic [DEPTH-1:0][WIDTH-1:0] fill_buf;
  logic                        fill_done;
  logic [CNT_W-1:0]            fill_cnt;
  logic [DEPTH-1:0][WIDTH-1:0] out_buf;
  logic [CNT_W-1:0]            out_cnt;
  logic                        out_valid;

  logic                        accept;
  logic                        complete;
  logic                        slot_free;
  logic [CNT_W-1:0]            frame_cnt;
  logic [DEPTH-1:0][WIDTH-1:0] frame_c;

  assign up_ready   = ~fill_done;
  assign down_valid = out_valid;
  assign down_data  = out_buf;
  assign down_count = out_cnt;

  assign accept    = up_valid & up_ready;
  assign complete  = accept & ((fill_idx == IDX_W'(DEPTH - 1)) | up_last);
  assign slot_free = ~out_valid | down_ready;
  assign frame_cnt = CNT_W'(fill_idx) + CNT_W'(1);

  // Closing frame: earlier slots from fill_buf, the current sample in its
  // slot, and zeros above it so stale samples never leak into a short frame.
  always_comb begin
    frame_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(fill_idx)) begin
        frame_c[i] = fill_buf[i];
      end else if (i == int'(fill_idx)) begin
        frame_c[i] = up_data;
      end else begin
        frame_c[i] = '0;
      end
    end
  end

  // Fill side: write accepted samples, close frames, stall a finished frame
  // in fill_buf when the output register is still occupied.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      fill_idx  <= '0;
      fill_buf  <= '0;
      fill_done <= 1'b0;
      fill_cnt  <= '0;
    end else begin
      if (complete) begin
        fill_idx <= '0;
        if (!slot_free) begin
          fill_buf  <= frame_c;
          fill_cnt  <= frame_cnt;
          fill_done <= 1'b1;
        end
      end else if (accept) begin
        fill_buf[fill_idx] <= up_data;
        fill_idx           <= fill_idx + IDX_W'(1);
      end
      // A stalled frame leaves fill_buf as soon as the output slot frees up;
      // no sample can be accepted in the same cycle since up_ready is low.
      if (fill_done && slot_free) begin
        fill_done <= 1'b0;
      end
    end
  end

  // Output side: load a frame directly from the fill path or from the
  // stalled fill_buf, otherwise drop valid once the consumer takes the frame.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_buf   <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fill_done && slot_free) begin
        out_buf   <= fill_buf;
        out_cnt   <= fill_cnt;
        out_valid <= 1'b1;
      end else if (complete && slot_free) begin
        out_buf   <= frame_c;
        out_cnt   <= frame_cnt;
        out_valid <= 1'b1;
      end else if (out_valid && down_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_collector.sv
// Testbench for sample_frame_collector (WIDTH=8, DEPTH=4): directed cases
// plus a randomized valid/ready run, checked through a frame scoreboard.
module tb_sample_frame_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [DEPTH-1:0][WIDTH-1:0] frame_t;
  typedef struct {
    frame_t           data;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic                 clk;
  logic                 arstn;
  logic                 up_valid;
  logic                 up_ready;
  logic [WIDTH-1:0]     up_data;
  logic                 up_last;
  logic                 down_valid;
  logic                 down_ready;
  frame_t               down_data;
  logic [CNT_W-1:0]     down_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   frames_seen = 0;
  exp_t exp_q[$];
  logic [WIDTH-1:0] part_q[$];

  logic   held = 1'b0;
  frame_t held_data;
  logic [CNT_W-1:0] held_cnt;

  bit rand_ready_en = 1'b0;
  bit rand_done     = 1'b0;

  sample_frame_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_count (down_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: collect handshaked samples into frames by the rules
  // (DEPTH samples or up_last closes a frame, unused slots are zero).
  always @(negedge clk) begin
    if (!arstn) begin
      part_q.delete();
      exp_q.delete();
    end else if (up_valid && up_ready) begin
      part_q.push_back(up_data);
      if (part_q.size() == DEPTH || up_last) begin
        exp_t e;
        e.data = '0;
        foreach (part_q[i]) e.data[i] = part_q[i];
        e.cnt = CNT_W'(part_q.size());
        exp_q.push_back(e);
        part_q.delete();
      end
    end
  end

  // Monitor: compare each accepted frame with the scoreboard, and check
  // that a stalled frame is held stable.
  always @(negedge clk) begin
    if (!arstn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", 64'(down_valid), 64'd1);
        check("stall_data",  64'(down_data),  64'(held_data));
        check("stall_count", 64'(down_count), 64'(held_cnt));
      end
      held = 1'b0;
      if (down_valid && down_ready) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'(down_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame_data",  64'(down_data),  64'(e.data));
          check("frame_count", 64'(down_count), 64'(e.cnt));
        end
      end else if (down_valid) begin
        held      = 1'b1;
        held_data = down_data;
        held_cnt  = down_count;
      end
    end
  end

  // Random consumer readiness during the random phase.
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1 down_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Drive one sample; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int waited = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    while (!up_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 500) check("send_timeout", 64'(waited), 64'd0);
    @(posedge clk); #1;
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs;
    arstn = 1'b0;
    up_valid = 1'b0;
    up_data = '0;
    up_last = 1'b0;
    down_ready = 1'b0;

    // Reset state
    #12;
    check("rst_down_valid", 64'(down_valid), 64'd0);
    check("rst_down_data",  64'(down_data),  64'd0);
    check("rst_down_count", 64'(down_count), 64'd0);
    check("rst_up_ready",   64'(up_ready),   64'd1);
    @(posedge clk); #2;
    arstn = 1'b1;
    idle(2);

    // Basic fill: one-cycle latency, up_ready stays high
    down_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("basic_not_early", 64'(down_valid), 64'd0);
    send(8'h44, 1'b0);
    check("basic_latency", 64'(down_valid), 64'd1);
    check("basic_data",    64'(down_data),  64'h44332211);
    check("basic_count",   64'(down_count), 64'd4);
    check("basic_up_ready", 64'(up_ready),  64'd1);
    idle(3);

    // Stream: 12 back-to-back samples, three frames
    fs = frames_seen;
    for (int i = 0; i < 12; i++) begin
      check("stream_up_ready", 64'(up_ready), 64'd1);
      send(8'(i), 1'b0);
    end
    idle(3);
    check("stream_frames", 64'(frames_seen - fs), 64'd3);

    // Backpressure: two frames, second stalls in fill_buf
    down_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), 1'b0);
    check("bp_up_ready_low", 64'(up_ready),   64'd0);
    check("bp_frame1_held",  64'(down_data),  64'h53525150);
    idle(2);
    check("bp_still_low",    64'(up_ready),   64'd0);
    down_ready = 1'b1;
    @(posedge clk); #1;
    down_ready = 1'b0;
    check("bp_frame2_valid", 64'(down_valid), 64'd1);
    check("bp_frame2_data",  64'(down_data),  64'h57565554);
    check("bp_up_ready_back", 64'(up_ready),  64'd1);
    idle(1);
    down_ready = 1'b1;
    idle(2);

    // Short frames via up_last, zero padding
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    check("short2_data",  64'(down_data),  64'h0000A2A1);
    check("short2_count", 64'(down_count), 64'd2);
    send(8'hB1, 1'b1);
    check("short1_data",  64'(down_data),  64'h000000B1);
    check("short1_count", 64'(down_count), 64'd1);
    idle(2);

    // Reset mid-operation with a pending frame
    down_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i), 1'b0);
    #2;
    arstn = 1'b0;
    #1;
    check("mrst_down_valid", 64'(down_valid), 64'd0);
    check("mrst_down_data",  64'(down_data),  64'd0);
    check("mrst_down_count", 64'(down_count), 64'd0);
    check("mrst_up_ready",   64'(up_ready),   64'd1);
    @(posedge clk); @(posedge clk); #2;
    arstn = 1'b1;
    idle(1);
    down_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 1'b0);
    check("post_rst_data",  64'(down_data),  64'hE3E2E1E0);
    check("post_rst_count", 64'(down_count), 64'd4);
    idle(2);

    // Random valid/ready/last
    rand_ready_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        up_data = 8'($urandom);
        up_last = 1'($urandom);
        @(posedge clk); #1;
      end
      send(8'($urandom), ($urandom_range(0, 3) == 0));
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #2;
    down_ready = 1'b1;
    begin
      int w = 0;
      while ((exp_q.size() != 0 || down_valid) && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      check("drain_timeout", 64'(w >= 200), 64'd0);
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    rand_done = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
